// File: rtl/trace_capture.sv
`default_nettype none
//==============================================================================
// Module      : trace_capture
// Description : Pen/cursor front end for the trace screen. Maps the pen onto a
//               4x4 cell grid, sets a cell bit after a dwell, and pulses when
//               the accumulated mask covers the displayed target trace.
// Revision    : 1.0 - initial release
//==============================================================================
module trace_capture #(
    parameter int unsigned GRID_X0      = 192,
    parameter int unsigned GRID_Y0      = 112,
    parameter int unsigned CELL_LOG2    = 6,
    parameter int unsigned DWELL        = 4,
    parameter int unsigned IDLE_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trace_screen_on,
    input  logic [9:0]  cursor_x,
    input  logic [9:0]  cursor_y,
    input  logic        pen_down,
    input  logic        clear_req,
    input  logic [15:0] target_trace,
    output logic [15:0] traced,
    output logic        cell_valid,
    output logic [3:0]  cell_idx,
    output logic        match_pulse,
    output logic [1:0]  state_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DRAWING = 2'd1;
    localparam logic [1:0] S_LIFTED  = 2'd2;
    localparam logic [1:0] S_MATCHED = 2'd3;

    // Grid bounds are compared at 11 bits so GRID_X0 + 256 cannot wrap.
    localparam logic [10:0] c_X_LO    = 11'(GRID_X0);
    localparam logic [10:0] c_X_HI    = 11'(GRID_X0 + (4 << CELL_LOG2));
    localparam logic [10:0] c_Y_LO    = 11'(GRID_Y0);
    localparam logic [10:0] c_Y_HI    = 11'(GRID_Y0 + (4 << CELL_LOG2));
    localparam logic [9:0]  c_X_OFF   = 10'(GRID_X0);
    localparam logic [9:0]  c_Y_OFF   = 10'(GRID_Y0);
    localparam logic [7:0]  c_DWELL   = 8'(DWELL);
    localparam logic [23:0] c_IDLE_TO = 24'(IDLE_TIMEOUT);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [15:0] r_traced;
    logic [15:0] w_traced_next;
    logic [15:0] r_target_q;
    logic [15:0] w_target_next;
    logic [23:0] r_idle;
    logic [23:0] w_idle_next;
    logic        r_match_pulse;
    logic        w_match_next;

    logic        r_cell_valid;
    logic [3:0]  r_cell_idx;
    logic        r_prev_valid;
    logic [3:0]  r_prev_idx;
    logic [7:0]  r_dwell;
    logic [7:0]  w_dwell_next;
    logic        r_hit;
    logic        w_hit;
    logic [3:0]  r_hit_idx;

    logic        w_inside;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic [1:0]  w_col;
    logic [1:0]  w_row;
    logic        w_same;
    logic        w_match;

    assign w_inside = ({1'b0, cursor_x} >= c_X_LO) && ({1'b0, cursor_x} < c_X_HI) &&
                      ({1'b0, cursor_y} >= c_Y_LO) && ({1'b0, cursor_y} < c_Y_HI);
    assign w_dx     = w_inside ? (cursor_x - c_X_OFF) : 10'd0;
    assign w_dy     = w_inside ? (cursor_y - c_Y_OFF) : 10'd0;
    assign w_col    = 2'(w_dx >> CELL_LOG2);
    assign w_row    = 2'(w_dy >> CELL_LOG2);

    assign w_same   = r_prev_valid && (r_cell_idx == r_prev_idx);
    assign w_match  = (r_target_q != 16'd0) && ((r_traced & r_target_q) == r_target_q);

    // Dwell count: restart at 1 on a new cell, saturate at DWELL; hit fires once per dwell.
    always_comb begin
        w_dwell_next = 8'd0;
        w_hit        = 1'b0;
        if (r_cell_valid) begin
            if (w_same) begin
                w_dwell_next = (r_dwell < c_DWELL) ? r_dwell + 8'd1 : r_dwell;
            end else begin
                w_dwell_next = 8'd1;
            end
            w_hit = (w_dwell_next == c_DWELL) && !(w_same && (r_dwell == c_DWELL));
        end
    end

    // Cell map and dwell registers; everything holds while the screen is off.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cell_valid <= 1'b0;
            r_cell_idx   <= 4'd0;
            r_prev_valid <= 1'b0;
            r_prev_idx   <= 4'd0;
            r_dwell      <= 8'd0;
            r_hit        <= 1'b0;
            r_hit_idx    <= 4'd0;
        end else if (trace_screen_on) begin
            r_cell_valid <= pen_down && w_inside;
            r_cell_idx   <= (pen_down && w_inside) ? {w_row, w_col} : 4'd0;
            r_prev_valid <= r_cell_valid;
            r_prev_idx   <= r_cell_idx;
            r_hit_idx    <= r_cell_idx;
            if (clear_req) begin
                r_dwell <= 8'd0;
                r_hit   <= 1'b0;
            end else begin
                r_dwell <= w_dwell_next;
                r_hit   <= w_hit;
            end
        end
    end

    // Next-state and mask update: clear_req > target change > match > bit set.
    always_comb begin
        w_state_next  = r_state;
        w_traced_next = r_traced;
        w_target_next = r_target_q;
        w_idle_next   = r_idle;
        w_match_next  = 1'b0;
        if (clear_req) begin
            w_traced_next = 16'd0;
            w_target_next = target_trace;
            w_idle_next   = 24'd0;
            w_state_next  = S_IDLE;
        end else if ((r_state != S_MATCHED) && (target_trace != r_target_q)) begin
            w_traced_next = 16'd0;
            w_target_next = target_trace;
            w_idle_next   = 24'd0;
            w_state_next  = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_traced_next = 16'd0;
                    w_idle_next   = 24'd0;
                    if (r_cell_valid) begin
                        w_state_next = S_DRAWING;
                    end
                end
                S_DRAWING: begin
                    if (w_match) begin
                        w_match_next = 1'b1;
                        w_state_next = S_MATCHED;
                    end else begin
                        if (r_hit) begin
                            w_traced_next = r_traced | (16'd1 << r_hit_idx);
                        end
                        if (!r_cell_valid) begin
                            w_idle_next  = 24'd0;
                            w_state_next = S_LIFTED;
                        end
                    end
                end
                S_LIFTED: begin
                    if (w_match) begin
                        w_match_next = 1'b1;
                        w_state_next = S_MATCHED;
                    end else if (r_cell_valid) begin
                        w_state_next = S_DRAWING;
                    end else if ((r_idle + 24'd1) == c_IDLE_TO) begin
                        w_traced_next = 16'd0;
                        w_idle_next   = 24'd0;
                        w_state_next  = S_IDLE;
                    end else begin
                        w_idle_next = r_idle + 24'd1;
                    end
                end
                default: begin
                    if (target_trace != r_target_q) begin
                        w_traced_next = 16'd0;
                        w_target_next = target_trace;
                        w_state_next  = S_IDLE;
                    end
                end
            endcase
        end
    end

    // State, mask, target latch and idle counter; the match pulse drops while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_traced      <= 16'd0;
            r_target_q    <= target_trace;
            r_idle        <= 24'd0;
            r_match_pulse <= 1'b0;
        end else if (trace_screen_on) begin
            r_state       <= w_state_next;
            r_traced      <= w_traced_next;
            r_target_q    <= w_target_next;
            r_idle        <= w_idle_next;
            r_match_pulse <= w_match_next;
        end else begin
            r_match_pulse <= 1'b0;
        end
    end

    assign traced      = r_traced;
    assign cell_valid  = r_cell_valid && trace_screen_on;
    assign cell_idx    = cell_valid ? r_cell_idx : 4'd0;
    assign match_pulse = r_match_pulse;
    assign state_out   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_trace_capture.sv
`default_nettype none
//==============================================================================
// Module      : tb_trace_capture
// Description : Directed self-checking bench for trace_capture (IDLE_TIMEOUT=16).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_trace_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_screen_on;
    logic [9:0]  cursor_x;
    logic [9:0]  cursor_y;
    logic        pen_down;
    logic        clear_req;
    logic [15:0] target_trace;
    logic [15:0] traced;
    logic        cell_valid;
    logic [3:0]  cell_idx;
    logic        match_pulse;
    logic [1:0]  state_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trace_capture #(
        .IDLE_TIMEOUT (16)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .trace_screen_on (trace_screen_on),
        .cursor_x        (cursor_x),
        .cursor_y        (cursor_y),
        .pen_down        (pen_down),
        .clear_req       (clear_req),
        .target_trace    (target_trace),
        .traced          (traced),
        .cell_valid      (cell_valid),
        .cell_idx        (cell_idx),
        .match_pulse     (match_pulse),
        .state_out       (state_out)
    );

    // Advance n clock edges; outputs are sampled 1 ns after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pen(input int x, input int y, input logic down);
        cursor_x = 10'(x);
        cursor_y = 10'(y);
        pen_down = down;
    endtask

    task automatic do_reset(input logic [15:0] tgt);
        reset           = 1'b1;
        trace_screen_on = 1'b1;
        clear_req       = 1'b0;
        target_trace    = tgt;
        pen(0, 0, 1'b0);
        step(2);
        check("rst_traced", 32'(traced), 32'h0);
        check("rst_valid", 32'(cell_valid), 32'h0);
        check("rst_idx", 32'(cell_idx), 32'h0);
        check("rst_match", 32'(match_pulse), 32'h0);
        check("rst_state", 32'(state_out), 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        // Dwell of 4 cycles in cell 0 sets bit 0 one cycle after the count completes.
        do_reset(16'h0000);
        pen(200, 120, 1'b1);
        step(1);
        check("t1_valid", 32'(cell_valid), 32'h1);
        check("t1_idx", 32'(cell_idx), 32'h0);
        step(1);
        check("t1_drawing", 32'(state_out), 32'h1);
        step(2);
        pen_down = 1'b0;
        step(1);
        check("t1_not_yet", 32'(traced), 32'h0);
        step(1);
        check("t1_bit0", 32'(traced), 32'h0001);
        check("t1_lifted", 32'(state_out), 32'h2);
        // Target change outside MATCHED clears the mask without a match.
        target_trace = 16'h0001;
        step(1);
        check("tchg_traced", 32'(traced), 32'h0);
        check("tchg_state", 32'(state_out), 32'h0);
        check("tchg_match", 32'(match_pulse), 32'h0);

        // Only three dwell cycles: no bit.
        do_reset(16'h0000);
        pen(200, 120, 1'b1);
        step(3);
        pen_down = 1'b0;
        step(4);
        check("t1_short", 32'(traced), 32'h0);

        // Match on target 0x0231 via cells 0, 4, 5, 9.
        do_reset(16'h0231);
        pen(200, 120, 1'b1);
        step(6);
        pen(200, 184, 1'b1);
        step(6);
        pen(264, 184, 1'b1);
        step(6);
        check("t2_three", 32'(traced), 32'h0031);
        check("t2_nomatch", 32'(match_pulse), 32'h0);
        pen(264, 248, 1'b1);
        step(6);
        check("t2_full", 32'(traced), 32'h0231);
        check("t2_pre_pulse", 32'(match_pulse), 32'h0);
        step(1);
        check("t2_pulse", 32'(match_pulse), 32'h1);
        check("t2_matched", 32'(state_out), 32'h3);
        step(1);
        check("t2_pulse_end", 32'(match_pulse), 32'h0);
        pen(447, 367, 1'b1);
        step(6);
        check("t2_frozen", 32'(traced), 32'h0231);
        check("t2_hold_state", 32'(state_out), 32'h3);

        // New target while MATCHED: clear, then accumulate against 0x0075.
        pen_down = 1'b0;
        step(2);
        target_trace = 16'h0075;
        step(1);
        check("t3_cleared", 32'(traced), 32'h0);
        check("t3_idle", 32'(state_out), 32'h0);
        pen(200, 120, 1'b1);
        step(6);
        check("t3_bit0", 32'(traced), 32'h0001);
        pen(328, 120, 1'b1);
        step(6);
        check("t3_bit2", 32'(traced), 32'h0005);
        check("t3_nomatch", 32'(match_pulse), 32'h0);
        check("t3_drawing", 32'(state_out), 32'h1);

        // Grid boundaries.
        do_reset(16'h0000);
        pen(100, 100, 1'b1);
        step(1);
        check("t4_outside", 32'(cell_valid), 32'h0);
        pen(448, 120, 1'b1);
        step(1);
        check("t4_x448", 32'(cell_valid), 32'h0);
        pen(300, 300, 1'b0);
        step(1);
        check("t4_penup", 32'(cell_valid), 32'h0);
        pen(447, 120, 1'b1);
        step(1);
        check("t4_x447_valid", 32'(cell_valid), 32'h1);
        check("t4_x447_idx", 32'(cell_idx), 32'h3);
        pen(447, 367, 1'b1);
        step(1);
        check("t4_corner", 32'(cell_idx), 32'hf);
        pen(192, 112, 1'b1);
        step(1);
        check("t4_origin", 32'(cell_idx), 32'h0);
        pen_down = 1'b0;
        step(1);
        check("t4_no_bit", 32'(traced), 32'h0);

        // Idle timeout after 16 lifted cycles.
        do_reset(16'h0000);
        pen(200, 120, 1'b1);
        step(4);
        pen_down = 1'b0;
        step(2);
        check("t5_lifted", 32'(state_out), 32'h2);
        step(15);
        check("t5_still_lifted", 32'(state_out), 32'h2);
        check("t5_still_bit", 32'(traced), 32'h0001);
        step(1);
        check("t5_timeout_state", 32'(state_out), 32'h0);
        check("t5_timeout_traced", 32'(traced), 32'h0);

        // Re-press at lifted cycle 10 keeps the mask.
        do_reset(16'h0000);
        pen(200, 120, 1'b1);
        step(4);
        pen_down = 1'b0;
        step(11);
        pen_down = 1'b1;
        step(2);
        check("t5_redraw_state", 32'(state_out), 32'h1);
        check("t5_redraw_bit", 32'(traced), 32'h0001);
        step(20);
        check("t5_kept", 32'(traced), 32'h0001);
        // Reset mid-stroke with the pen still down.
        reset = 1'b1;
        step(1);
        check("midrst_traced", 32'(traced), 32'h0);
        check("midrst_state", 32'(state_out), 32'h0);
        check("midrst_valid", 32'(cell_valid), 32'h0);
        reset = 1'b0;

        // clear_req coincides with the bit-set cycle.
        do_reset(16'h0000);
        pen(200, 120, 1'b1);
        step(5);
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        pen_down  = 1'b0;
        check("t6_clr_traced", 32'(traced), 32'h0);
        check("t6_clr_state", 32'(state_out), 32'h0);
        step(4);
        check("t6_clr_stays", 32'(traced), 32'h0);

        // Screen disabled for 50 cycles mid-dwell; the dwell resumes afterwards.
        do_reset(16'h0000);
        pen(200, 120, 1'b1);
        step(3);
        trace_screen_on = 1'b0;
        step(1);
        check("t6_off_valid", 32'(cell_valid), 32'h0);
        step(49);
        check("t6_off_traced", 32'(traced), 32'h0);
        check("t6_off_state", 32'(state_out), 32'h1);
        check("t6_off_match", 32'(match_pulse), 32'h0);
        trace_screen_on = 1'b1;
        step(1);
        check("t6_on_valid", 32'(cell_valid), 32'h1);
        check("t6_on_a", 32'(traced), 32'h0);
        step(1);
        check("t6_on_b", 32'(traced), 32'h0);
        step(1);
        check("t6_resumed", 32'(traced), 32'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Player-input front end for the trace screen. It sits directly upstream of the trace-checking stage and produces the 16-bit p1_traced or p2_traced mask; one instance is used per player.
- It maps a pen or cursor position onto a 4x4 cell grid and sets a cell's bit once the pen has dwelt in that cell.
- It reports a one-cycle match when the accumulated mask covers the currently displayed target trace.
- It clears itself when the target changes, on an idle timeout, or on request.

Parameters:
- GRID_X0, 192, left pixel column of the grid region.
- GRID_Y0, 112, top pixel row of the grid region.
- CELL_LOG2, 6, log2 of the cell edge in pixels (cells are 64x64, so the region is 256x256).
- DWELL, 4, consecutive in-cell pen_down cycles required to set a bit (1..255).
- IDLE_TIMEOUT, 1000000, pen-up cycles in LIFTED before an auto-clear (1..2^24-1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- trace_screen_on  in  1  enable; when low, hold state and ignore input
- cursor_x  in  10  pen x in pixels
- cursor_y  in  10  pen y in pixels
- pen_down  in  1  pen or button pressed
- clear_req  in  1  one-cycle request to clear the mask
- target_trace  in  16  trace currently displayed
- traced  out  16  accumulated cell mask (bit = row*4+col; bit0 = top-left)
- cell_valid  out  1  registered: pen_down and cursor inside the grid
- cell_idx  out  4  registered current cell index (0 when cell_valid=0)
- match_pulse  out  1  one-cycle pulse when the mask covers the target
- state_out  out  2  current state encoding

Behaviour:
- Reset: traced=0, cell_valid=0, cell_idx=0, match_pulse=0, state=IDLE(0), dwell and idle counters=0, target_q=target_trace.
- Cell map, combinational then registered with 1-cycle latency:
  - inside when GRID_X0 <= x < GRID_X0+4<<CELL_LOG2, and likewise for y with GRID_Y0.
  - col = (x-GRID_X0)>>CELL_LOG2, row likewise; subtraction is 10-bit and done only when inside.
- Dwell counter (8-bit):
  - Increments while cell_valid and cell_idx is equal to the previous cycle's cell_idx.
  - Resets to 1 on a cell change; resets to 0 when cell_valid=0.
  - When the count reaches DWELL, set traced[cell_idx]. The bit is visible the cycle after the count hits DWELL.
  - The counter then saturates, so the bit is not re-set.
  - Setting an already-set bit is a no-op. Bits are never cleared individually.
- States:
  - IDLE(0): traced=0. pen_down inside the grid -> DRAWING.
  - DRAWING(1): accumulate bits. pen_down=0 -> LIFTED; the idle counter clears on entry.
  - LIFTED(2): no accumulation. The idle counter increments each cycle.
    - pen_down inside the grid -> DRAWING, mask retained.
    - Counter reaches IDLE_TIMEOUT -> clear traced, go to IDLE.
  - MATCHED(3): traced held frozen and input ignored until target_trace != target_q. Then clear traced, latch target_q, go to IDLE.
- Match condition, checked in DRAWING or LIFTED on the registered traced: target_q != 0 and (traced & target_q) == target_q. It raises match_pulse for exactly 1 cycle and enters MATCHED the same cycle. Extra bits beyond the target are allowed.
- Target change in any state other than MATCHED: clear traced, latch target_q, go to IDLE, no match_pulse. This takes priority over setting a bit in the same cycle.
- clear_req: clear traced, counters and target_q refresh, go to IDLE. Priority order: reset > clear_req > target change > match > bit set.
- trace_screen_on=0:
  - All registers hold, including the counters.
  - match_pulse=0 and cell_valid=0.
  - When it goes high again, operation resumes in the same state.
- Reset mid-stroke returns to the reset values in the next cycle regardless of pen_down.

Test Plan:
1. Reset, then pen_down at (200,120) for 4 cycles -> cell_idx=0, traced=16'h0001 one cycle after the dwell completes. Three cycles only -> traced stays 16'h0000.
2. target_trace=16'h0231. Dwell cells 0, 4, 5 and 9, e.g. (200,120) then (200,184), (264,184), (264,248) -> match_pulse high exactly 1 cycle after bit 9 sets, state_out=3, traced=16'h0231 held.
3. In MATCHED, change target_trace to 16'h0075 -> next cycle traced=0, state_out=0; the new stroke accumulates against 16'h0075.
4. Pen outside the grid at (100,100), or exactly at x=448 -> cell_valid=0 and no bit set. At x=447 -> cell_idx col=3.
5. With IDLE_TIMEOUT=16, draw bit 0, then lift the pen -> state LIFTED; after 16 cycles traced=0 and state IDLE. Re-pressing at cycle 10 keeps traced=16'h0001.
6. clear_req and dwell completion in the same cycle -> traced=0 and state IDLE. With trace_screen_on low for 50 cycles mid-dwell -> no bit set and counters frozen; the dwell resumes afterwards.
